// File: rtl/bp_update_scheduler_if.sv
// Bus between the fetch/execute pipeline and the branch-predictor update
// scheduler. The pipeline side is the master, the scheduler is the slave.
interface bp_update_scheduler_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  // pipeline control
  logic          stall;

  // fetch-side allocation
  logic          fetch_valid;
  logic [31:0]   fetch_pc;
  logic [6:0]    fetch_opcode;
  logic          fetch_local_pred;
  logic          fetch_global_pred;
  logic          fetch_pred_br;
  logic          fetch_ready;

  // execute-side resolution
  logic          resolve_valid;
  logic          resolve_br_en;

  // predictor-table write-back
  logic          pred_ld;
  logic [31:0]   write_pc;
  logic          cpu_br_en;
  logic          upd_local_pred;
  logic          upd_global_pred;
  logic          mispredict;

  // status
  logic [CW-1:0] occupancy;
  logic          resolve_err;

  modport master (
    output stall,
    output fetch_valid, fetch_pc, fetch_opcode,
    output fetch_local_pred, fetch_global_pred, fetch_pred_br,
    output resolve_valid, resolve_br_en,
    input  fetch_ready,
    input  pred_ld, write_pc, cpu_br_en, upd_local_pred, upd_global_pred,
    input  mispredict, occupancy, resolve_err
  );

  modport slave (
    input  stall,
    input  fetch_valid, fetch_pc, fetch_opcode,
    input  fetch_local_pred, fetch_global_pred, fetch_pred_br,
    input  resolve_valid, resolve_br_en,
    output fetch_ready,
    output pred_ld, write_pc, cpu_br_en, upd_local_pred, upd_global_pred,
    output mispredict, occupancy, resolve_err
  );
endinterface

// File: rtl/bp_update_scheduler.sv
// Branch-predictor update scheduler: remembers the predictions of every
// in-flight conditional branch in fetch order and, when the oldest one
// resolves, writes its PC, outcome and component predictions back to the
// predictor tables one cycle later. A misprediction flushes all younger
// (wrong-path) entries.
module bp_update_scheduler #(
  parameter int         DEPTH     = 4,
  parameter logic [6:0] BR_OPCODE = 7'b1100011
) (
  input  logic               clk,
  input  logic               rst,
  bp_update_scheduler_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic        local_pred;
    logic        global_pred;
    logic        pred_br;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;

  logic [PW-1:0] head_d, tail_d;
  logic [CW-1:0] count_d;
  logic          wr_en;

  entry_t        head_entry;
  entry_t        new_entry;
  logic          alloc;
  logic          res_acc;
  logic          res_err;
  logic          flush;

  // Readiness depends on the registered count only, so a resolve in the
  // same cycle never frees a slot for the fetch being presented.
  assign bus.fetch_ready = (count_q != FULL);
  assign bus.occupancy   = count_q;

  assign head_entry = mem[head_q];
  assign new_entry  = '{pc:          bus.fetch_pc,
                        local_pred:  bus.fetch_local_pred,
                        global_pred: bus.fetch_global_pred,
                        pred_br:     bus.fetch_pred_br};

  assign alloc   = bus.fetch_valid & ~bus.stall & bus.fetch_ready &
                   (bus.fetch_opcode == BR_OPCODE);
  assign res_acc = bus.resolve_valid & ~bus.stall & (count_q != '0);
  assign res_err = bus.resolve_valid & ~bus.stall & (count_q == '0);
  assign flush   = res_acc & (head_entry.pred_br != bus.resolve_br_en);

  // Next pointer/count: a flush drops every younger entry, including a
  // wrong-path allocation arriving in the same cycle.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    wr_en   = 1'b0;
    if (flush) begin
      head_d  = head_q + PW'(1);
      tail_d  = head_q + PW'(1);
      count_d = '0;
    end else begin
      if (alloc) begin
        wr_en  = 1'b1;
        tail_d = tail_q + PW'(1);
      end
      if (res_acc) begin
        head_d = head_q + PW'(1);
      end
      if (alloc && !res_acc) begin
        count_d = count_q + CW'(1);
      end else if (!alloc && res_acc) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    // NOTE: the entry array is deliberately not reset; an entry is only
    // ever read after it has been written, and count gates validity.
    if (wr_en) begin
      mem[tail_q] <= new_entry;
    end
  end

  // Write-back strobes pulse for one cycle; data fields hold their last
  // value between accepted resolves.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.pred_ld         <= 1'b0;
      bus.mispredict      <= 1'b0;
      bus.resolve_err     <= 1'b0;
      bus.write_pc        <= '0;
      bus.cpu_br_en       <= 1'b0;
      bus.upd_local_pred  <= 1'b0;
      bus.upd_global_pred <= 1'b0;
    end else begin
      bus.pred_ld     <= res_acc;
      bus.mispredict  <= flush;
      bus.resolve_err <= res_err;
      if (res_acc) begin
        bus.write_pc        <= head_entry.pc;
        bus.cpu_br_en       <= bus.resolve_br_en;
        bus.upd_local_pred  <= head_entry.local_pred;
        bus.upd_global_pred <= head_entry.global_pred;
      end
    end
  end
endmodule

// File: tb/tb_bp_update_scheduler.sv
// Scoreboard bench for bp_update_scheduler: the stimulus process runs a
// queue-based reference model and posts the expected write-back pulses;
// a monitor process compares them against the DUT on the falling edge.
module tb_bp_update_scheduler;
  localparam int         DEPTH = 4;
  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] ALU   = 7'b0010011;

  typedef struct {
    logic [31:0] pc;
    logic        lp;
    logic        gp;
    logic        pb;
  } mentry_t;

  typedef struct {
    logic pld;
    logic err;
    logic mp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bp_update_scheduler_if #(.DEPTH(DEPTH)) bus ();

  bp_update_scheduler #(.DEPTH(DEPTH), .BR_OPCODE(BR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // reference model state
  mentry_t     m_q[$];
  exp_t        sb[$];
  logic [31:0] h_wpc = '0;
  logic        h_be  = 1'b0;
  logic        h_lp  = 1'b0;
  logic        h_gp  = 1'b0;
  logic        mon_en = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // One clock of stimulus; the model computes from pre-edge state and
  // commits right after the edge, exactly when the DUT state changes.
  task automatic step(input logic r, input logic st, input logic fv,
                      input logic [31:0] pc, input logic [6:0] op,
                      input logic lp, input logic gp, input logic pb,
                      input logic rv, input logic be);
    mentry_t nq[$];
    mentry_t hd;
    exp_t    e;
    logic    push, upd, alloc, mp;
    rst                   = r;
    bus.stall             = st;
    bus.fetch_valid       = fv;
    bus.fetch_pc          = pc;
    bus.fetch_opcode      = op;
    bus.fetch_local_pred  = lp;
    bus.fetch_global_pred = gp;
    bus.fetch_pred_br     = pb;
    bus.resolve_valid     = rv;
    bus.resolve_br_en     = be;
    nq   = m_q;
    push = 1'b0;
    upd  = 1'b0;
    hd   = '{pc: '0, lp: 1'b0, gp: 1'b0, pb: 1'b0};
    e    = '{pld: 1'b0, err: 1'b0, mp: 1'b0};
    if (!r && !st) begin
      alloc = fv && (m_q.size() != DEPTH) && (op == BR);
      if (rv && m_q.size() == 0) begin
        push = 1'b1;
        e    = '{pld: 1'b0, err: 1'b1, mp: 1'b0};
        if (alloc) nq.push_back('{pc: pc, lp: lp, gp: gp, pb: pb});
      end else if (rv) begin
        hd   = nq.pop_front();
        mp   = (hd.pb != be);
        push = 1'b1;
        upd  = 1'b1;
        e    = '{pld: 1'b1, err: 1'b0, mp: mp};
        if (mp) nq.delete();
        else if (alloc) nq.push_back('{pc: pc, lp: lp, gp: gp, pb: pb});
      end else if (alloc) begin
        nq.push_back('{pc: pc, lp: lp, gp: gp, pb: pb});
      end
    end
    @(posedge clk);
    if (r) begin
      m_q.delete();
      h_wpc = '0; h_be = 1'b0; h_lp = 1'b0; h_gp = 1'b0;
    end else begin
      m_q = nq;
      if (upd) begin
        h_wpc = hd.pc; h_be = be; h_lp = hd.lp; h_gp = hd.gp;
      end
      if (push) sb.push_back(e);
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'h0, ALU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fetch(input logic [31:0] pc, input logic pb);
    step(1'b0, 1'b0, 1'b1, pc, BR, pb, ~pb, pb, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic be);
    step(1'b0, 1'b0, 1'b0, 32'h0, ALU, 1'b0, 1'b0, 1'b0, 1'b1, be);
  endtask

  task automatic fetch_resolve(input logic [31:0] pc, input logic pb, input logic be);
    step(1'b0, 1'b0, 1'b1, pc, BR, pb, pb, pb, 1'b1, be);
  endtask

  // Monitor: compares status every cycle and consumes one scoreboard
  // entry per write-back or error pulse.
  initial begin
    exp_t it;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("occupancy", 32'(bus.occupancy), 32'(m_q.size()));
        check("fetch_ready", 32'(bus.fetch_ready), 32'(m_q.size() != DEPTH));
        if (bus.pred_ld || bus.resolve_err) begin
          if (sb.size() == 0) begin
            check("unexpected_pulse", 32'({bus.pred_ld, bus.resolve_err}), 32'h0);
          end else begin
            it = sb.pop_front();
            check("pred_ld", 32'(bus.pred_ld), 32'(it.pld));
            check("resolve_err", 32'(bus.resolve_err), 32'(it.err));
            check("mispredict", 32'(bus.mispredict), 32'(it.mp));
          end
        end else begin
          check("idle_mispredict", 32'(bus.mispredict), 32'h0);
          if (sb.size() != 0) begin
            it = sb.pop_front();
            check("missing_pulse", 32'({bus.pred_ld, bus.resolve_err}),
                  32'({it.pld, it.err}));
          end
        end
        check("write_pc", bus.write_pc, h_wpc);
        check("cpu_br_en", 32'(bus.cpu_br_en), 32'(h_be));
        check("upd_local_pred", 32'(bus.upd_local_pred), 32'(h_lp));
        check("upd_global_pred", 32'(bus.upd_global_pred), 32'(h_gp));
      end
    end
  end

  initial begin
    logic        r, st, fv, lp, gp, pb, rv, be;
    logic [6:0]  op;

    // reset and reset-state values
    step(1'b1, 1'b0, 1'b0, 32'h0, ALU, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    check("rst_occupancy", 32'(bus.occupancy), 32'h0);
    check("rst_fetch_ready", 32'(bus.fetch_ready), 32'h1);
    check("rst_pred_ld", 32'(bus.pred_ld), 32'h0);
    check("rst_write_pc", bus.write_pc, 32'h0);
    idle();

    // two correctly predicted branches
    fetch(32'h100, 1'b1);
    fetch(32'h104, 1'b1);
    check("two_alloc_occ", 32'(bus.occupancy), 32'h2);
    resolve(1'b1);
    resolve(1'b1);
    idle();

    // fill, overflow attempt, resolve+fetch while full
    fetch(32'h200, 1'b1);
    fetch(32'h204, 1'b0);
    fetch(32'h208, 1'b1);
    fetch(32'h20c, 1'b1);
    check("full_ready", 32'(bus.fetch_ready), 32'h0);
    fetch(32'h210, 1'b1);
    fetch_resolve(32'h214, 1'b1, 1'b1);
    check("full_resolve_occ", 32'(bus.occupancy), 32'h3);
    resolve(1'b0);
    resolve(1'b1);
    resolve(1'b1);
    idle();

    // mispredict flushes younger entries
    fetch(32'h300, 1'b1);
    fetch(32'h304, 1'b1);
    fetch(32'h308, 1'b0);
    resolve(1'b0);
    idle();

    // mispredict with same-cycle wrong-path fetch, then empty resolve
    fetch(32'h400, 1'b1);
    fetch(32'h404, 1'b1);
    fetch_resolve(32'h408, 1'b1, 1'b0);
    resolve(1'b1);
    idle();

    // empty resolve, non-branch fetch, stall freezing everything
    resolve(1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h4f0, ALU, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    fetch(32'h500, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h504, BR, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0, ALU, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    resolve(1'b0);
    idle();

    // pointer wrap with alternating allocate/resolve
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) fetch(32'h600 + 32'(4 * i), 1'b1);
      else            resolve(1'b1);
    end
    fetch(32'h700, 1'b1);
    fetch(32'h704, 1'b0);
    // reset overrides a simultaneous fetch and resolve
    step(1'b1, 1'b0, 1'b1, 32'h708, BR, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("midrst_occ", 32'(bus.occupancy), 32'h0);
    check("midrst_ready", 32'(bus.fetch_ready), 32'h1);
    idle();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(99) < 2);
      st = ($urandom_range(99) < 10);
      fv = ($urandom_range(99) < 60);
      op = ($urandom_range(99) < 75) ? BR : ALU;
      lp = 1'($urandom);
      gp = 1'($urandom);
      pb = 1'($urandom);
      rv = ($urandom_range(99) < 40);
      be = ($urandom_range(99) < 75) ? pb : 1'($urandom);
      if (rv && m_q.size() != 0) be = ($urandom_range(99) < 75) ? m_q[0].pb : ~m_q[0].pb;
      step(r, st, fv, 32'($urandom) & 32'hffff_fffc, op, lp, gp, pb, rv, be);
    end

    idle();
    idle();
    check("scoreboard_empty", 32'(sb.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
